// File: rtl/conv3x3_accumulator.sv
// 3x3 window dot product with per-column accumulation across input layers; after the last layer
// of a row each column's sum is ReLU'd, right-shifted and saturated to one 8-bit output pixel.
module conv3x3_accumulator #(
    parameter int unsigned MAX_LAYERS  = 512,
    parameter int unsigned MAX_COLS    = 64,
    parameter int unsigned ACC_W       = 32,
    parameter int unsigned OFIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_start,
    input  logic [9:0]  cfg_no_of_layers,
    input  logic [9:0]  cfg_col_size,
    input  logic [3:0]  cfg_shift,
    input  logic        wt_we,
    input  logic [9:0]  wt_addr,
    input  logic [71:0] wt_data,
    input  logic [71:0] in_data,
    input  logic        in_valid,
    output logic        in_rdy,
    input  logic [9:0]  in_id,
    output logic [7:0]  out_data,
    output logic [9:0]  out_row,
    output logic [9:0]  out_col,
    output logic        out_valid,
    input  logic        out_rdy,
    output logic        cfg_error
);
    localparam int unsigned LAW = $clog2(MAX_LAYERS);
    localparam int unsigned CAW = $clog2(MAX_COLS);
    localparam int unsigned FAW = $clog2(OFIFO_DEPTH);
    localparam int unsigned FEW = 28;

    function automatic logic signed [16:0] tap_mul(input logic [7:0] px, input logic [7:0] wt);
        logic signed [16:0] a;
        logic signed [16:0] b;
        a = {9'b0, px};
        b = {{9{wt[7]}}, wt};
        return a * b;
    endfunction

    logic flush;
    logic cfg_bad;
    logic cur_last;
    logic accept;
    logic pop;
    logic push;
    logic [9:0] row_q, layer_q, col_q;
    logic cfg_error_q;

    logic [71:0] kern_mem [MAX_LAYERS];
    logic signed [ACC_W-1:0] acc_mem [MAX_COLS];
    logic [FEW-1:0] fifo_mem [OFIFO_DEPTH];
    logic [FAW-1:0] wr_ptr, rd_ptr;
    logic [FAW:0] fifo_cnt;

    logic s1_valid, s2_valid, s3_valid, s4_valid;
    logic s1_first, s2_first, s3_first;
    logic s1_last, s2_last, s3_last, s4_last;
    logic [9:0] s1_row, s2_row, s3_row, s4_row;
    logic [9:0] s1_col, s2_col, s3_col, s4_col;
    logic [71:0] s1_pix;
    logic [71:0] kern_rd;
    logic signed [16:0] prod_q [9];
    logic signed [20:0] sum;
    logic signed [20:0] s3_sum;
    logic signed [ACC_W-1:0] acc_rd;
    logic signed [ACC_W-1:0] acc_new;
    logic signed [ACC_W-1:0] s4_acc;
    logic [ACC_W-1:0] relu;
    logic [ACC_W-1:0] shifted;
    logic [7:0] pix;
    logic [FAW+2:0] pending;

    assign flush   = !reset_n || cfg_start;
    assign cfg_bad = (cfg_col_size < 10'd4) || (cfg_col_size > 10'(MAX_COLS)) ||
                     (cfg_no_of_layers == '0) || (cfg_no_of_layers > 10'(MAX_LAYERS));
    assign cur_last = (layer_q == cfg_no_of_layers - 10'd1);

    // Last-layer beats already accepted but not yet popped each own a FIFO slot.
    assign pending = (FAW+3)'(fifo_cnt) + (FAW+3)'(s1_valid & s1_last) +
                     (FAW+3)'(s2_valid & s2_last) + (FAW+3)'(s3_valid & s3_last) +
                     (FAW+3)'(s4_valid & s4_last);

    assign in_rdy = reset_n && !cfg_start && !cfg_bad &&
                    (!cur_last || (pending < (FAW+3)'(OFIFO_DEPTH)));
    assign accept = in_valid && in_rdy;
    assign cfg_error = cfg_error_q;

    always_ff @(posedge clk) begin
        if (flush) begin
            row_q   <= '0;
            layer_q <= '0;
            col_q   <= '0;
        end else if (accept) begin
            if (col_q == cfg_col_size - 10'd1) begin
                col_q <= '0;
                if (cur_last) begin
                    layer_q <= '0;
                    row_q   <= row_q + 10'd1;
                end else begin
                    layer_q <= layer_q + 10'd1;
                end
            end else begin
                col_q <= col_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            cfg_error_q <= 1'b0;
        end else if (cfg_bad || (accept && (in_id != layer_q))) begin
            cfg_error_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s4_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            s4_valid <= s3_valid;
        end
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < 9; k++) begin
            sum = sum + {{4{prod_q[k][16]}}, prod_q[k]};
        end
    end

    assign acc_new = s3_first ? ACC_W'(s3_sum) : acc_rd + ACC_W'(s3_sum);

    // Datapath and RAMs carry no reset; stage valids above qualify them.
    always_ff @(posedge clk) begin
        if (wt_we && (wt_addr < 10'(MAX_LAYERS))) begin
            kern_mem[wt_addr[LAW-1:0]] <= wt_data;
        end
        if (accept) begin
            s1_pix   <= in_data;
            s1_row   <= row_q;
            s1_col   <= col_q;
            s1_first <= (layer_q == '0);
            s1_last  <= cur_last;
            kern_rd  <= kern_mem[layer_q[LAW-1:0]];
        end
        for (int k = 0; k < 9; k++) begin
            prod_q[k] <= tap_mul(s1_pix[8*k +: 8], kern_rd[8*k +: 8]);
        end
        s2_row   <= s1_row;
        s2_col   <= s1_col;
        s2_first <= s1_first;
        s2_last  <= s1_last;
        s3_sum   <= sum;
        acc_rd   <= acc_mem[s2_col[CAW-1:0]];
        s3_row   <= s2_row;
        s3_col   <= s2_col;
        s3_first <= s2_first;
        s3_last  <= s2_last;
        if (s3_valid) begin
            acc_mem[s3_col[CAW-1:0]] <= acc_new;
        end
        s4_acc  <= acc_new;
        s4_row  <= s3_row;
        s4_col  <= s3_col;
        s4_last <= s3_last;
    end

    always_comb begin
        relu    = s4_acc[ACC_W-1] ? '0 : s4_acc;
        shifted = relu >> cfg_shift;
        pix     = (shifted > ACC_W'(255)) ? 8'hFF : shifted[7:0];
    end

    assign push      = s4_valid && s4_last;
    assign out_valid = (fifo_cnt != '0);
    assign pop       = out_valid && out_rdy;
    assign {out_data, out_row, out_col} = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < int'(OFIFO_DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {pix, s4_row, s4_col};
                wr_ptr <= wr_ptr + FAW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FAW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (FAW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (FAW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!flush && push && !pop) begin
            assert (fifo_cnt < (FAW+1)'(OFIFO_DEPTH));
        end
    end
`endif

endmodule

// File: tb/tb_conv3x3_accumulator.sv
// Bench for conv3x3_accumulator: directed and randomized windows checked every cycle against a
// behavioural model (counters, kernel copy, per-column sums, queue of owed outputs).
module tb_conv3x3_accumulator;
    logic clk = 1'b0;
    logic reset_n, cfg_start, wt_we, in_valid, in_rdy, out_valid, out_rdy, cfg_error;
    logic [9:0] cfg_no_of_layers, cfg_col_size, wt_addr, in_id, out_row, out_col;
    logic [3:0] cfg_shift;
    logic [71:0] wt_data, in_data;
    logic [7:0] out_data;

    always #5 clk = ~clk;

    conv3x3_accumulator dut (
        .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start),
        .cfg_no_of_layers(cfg_no_of_layers), .cfg_col_size(cfg_col_size),
        .cfg_shift(cfg_shift), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
        .in_data(in_data), .in_valid(in_valid), .in_rdy(in_rdy), .in_id(in_id),
        .out_data(out_data), .out_row(out_row), .out_col(out_col), .out_valid(out_valid),
        .out_rdy(out_rdy), .cfg_error(cfg_error)
    );

    typedef struct { int pix; int row; int col; } out_t;

    out_t exp_q[$];
    out_t got_q[$];
    logic [71:0] m_kern [512];
    int m_acc [64];
    int m_row = 0, m_layer = 0, m_col = 0;
    bit m_err = 0, chk_en = 0, rnd_rdy = 0;
    int n_cmp = 0, n_bad = 0;
    int cyc = 0, n_dut_acc = 0, first_acc_cyc = -1, first_out_cyc = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int dot(input logic [71:0] px, input logic [71:0] wt);
        int s = 0;
        for (int k = 0; k < 9; k++) s += int'(px[8*k +: 8]) * int'($signed(wt[8*k +: 8]));
        return s;
    endfunction

    function automatic int sat_pix(input int acc, input int sh);
        longint t;
        t = (acc < 0) ? 0 : longint'(acc);
        t = t >> sh;
        return (t > 255) ? 255 : int'(t);
    endfunction

    function automatic logic [71:0] fill(input logic [7:0] b);
        return {9{b}};
    endfunction

    function automatic logic [71:0] rand72();
        return {$urandom(), $urandom(), 8'($urandom())};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            out_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    // Model step: inputs are stable from posedge+1 to the next posedge, so decide that edge here.
    always @(negedge clk) begin
        bit exp_rdy, cfg_ok, cur_last;
        int nl, nc, s;
        out_t e;
        nl = int'(cfg_no_of_layers);
        nc = int'(cfg_col_size);
        cfg_ok = (nc >= 4) && (nc <= 64) && (nl >= 1) && (nl <= 512);
        cur_last = (m_layer == nl - 1);
        exp_rdy = reset_n && !cfg_start && cfg_ok && (!cur_last || (exp_q.size() < 4));
        if (chk_en) begin
            check("in_rdy", in_rdy, exp_rdy);
            check("cfg_error", cfg_error, m_err);
            if (exp_q.size() == 0) begin
                check("out_valid_idle", out_valid, 0);
            end else if (out_valid) begin
                check("out_data", out_data, exp_q[0].pix);
                check("out_row", out_row, exp_q[0].row);
                check("out_col", out_col, exp_q[0].col);
            end
            if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
        end
        if (in_valid && in_rdy && reset_n) n_dut_acc++;
        if (!reset_n || cfg_start) begin
            m_row = 0;
            m_layer = 0;
            m_col = 0;
            m_err = 0;
            exp_q.delete();
        end else begin
            if (out_valid && out_rdy && exp_q.size() > 0) begin
                e.pix = int'(out_data);
                e.row = int'(out_row);
                e.col = int'(out_col);
                got_q.push_back(e);
                void'(exp_q.pop_front());
            end
            if (in_valid && exp_rdy) begin
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                if (int'(in_id) != m_layer) m_err = 1;
                s = dot(in_data, m_kern[m_layer]);
                m_acc[m_col] = (m_layer == 0) ? s : m_acc[m_col] + s;
                if (cur_last) begin
                    e.pix = sat_pix(m_acc[m_col], int'(cfg_shift));
                    e.row = m_row;
                    e.col = m_col;
                    exp_q.push_back(e);
                end
                if (m_col == nc - 1) begin
                    m_col = 0;
                    if (cur_last) begin
                        m_layer = 0;
                        m_row = (m_row + 1) % 1024;
                    end else begin
                        m_layer++;
                    end
                end else begin
                    m_col++;
                end
            end
            if (!cfg_ok) m_err = 1;
        end
        if (wt_we && wt_addr < 10'd512) m_kern[wt_addr[8:0]] = wt_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n, input int c, input int sh);
        cfg_no_of_layers = 10'(n);
        cfg_col_size = 10'(c);
        cfg_shift = 4'(sh);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic load_kernel(input int layer, input logic [71:0] k);
        wt_we = 1'b1;
        wt_addr = 10'(layer);
        wt_data = k;
        tick();
        wt_we = 1'b0;
    endtask

    task automatic send(input logic [71:0] px, input int id);
        bit took = 0;
        in_valid = 1'b1;
        in_data = px;
        in_id = 10'(id);
        for (int i = 0; i < 300 && !took; i++) begin
            @(negedge clk);
            took = in_rdy;
            tick();
        end
        in_valid = 1'b0;
        check("send_accepted", took, 1);
    endtask

    task automatic drain();
        int i = 0;
        while (exp_q.size() != 0 && i < 500) begin
            tick();
            i++;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (6) tick();
    endtask

    // Checks every captured output of a row against one literal pixel value and cols 0..n-1.
    task automatic check_row(input string tag, input int n, input int pix);
        check({tag, "_count"}, got_q.size(), n);
        for (int i = 0; i < got_q.size(); i++) begin
            check({tag, "_pix"}, got_q[i].pix, pix);
            check({tag, "_row"}, got_q[i].row, 0);
            check({tag, "_col"}, got_q[i].col, i);
        end
    endtask

    task automatic run_single(input string tag, input logic [7:0] w, input logic [7:0] p,
                              input int sh, input int pix);
        load_kernel(0, fill(w));
        do_start(1, 4, sh);
        got_q.delete();
        for (int c = 0; c < 4; c++) send(fill(p), 0);
        drain();
        check_row(tag, 4, pix);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got time limit, expected completion");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; cfg_start = 1'b0; cfg_no_of_layers = 10'd1; cfg_col_size = 10'd4;
        cfg_shift = 4'd0; wt_we = 1'b0; wt_addr = '0; wt_data = '0; in_data = '0;
        in_valid = 1'b0; in_id = '0; out_rdy = 1'b1;
        tick();
        tick();
        chk_en = 1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_row", out_row, 0);
        check("rst_out_col", out_col, 0);
        check("rst_in_rdy", in_rdy, 0);
        tick();
        reset_n = 1'b1;

        // Single layer, unit weights: latency and literal values.
        load_kernel(0, fill(8'd1));
        do_start(1, 4, 0);
        got_q.delete();
        first_acc_cyc = -1;
        first_out_cyc = -1;
        for (int c = 0; c < 4; c++) send(fill(8'd1), 0);
        drain();
        check("t1_latency", first_out_cyc - first_acc_cyc, 5);
        check_row("t1", 4, 9);

        // Three layers accumulate 2*9*(1+2-1).
        load_kernel(0, fill(8'd1));
        load_kernel(1, fill(8'd2));
        load_kernel(2, fill(8'hFF));
        do_start(3, 4, 0);
        got_q.delete();
        for (int l = 0; l < 2; l++) for (int c = 0; c < 4; c++) send(fill(8'd2), l);
        repeat (6) tick();
        check("t2_quiet_valid", out_valid, 0);
        check("t2_quiet_count", got_q.size(), 0);
        for (int c = 0; c < 4; c++) send(fill(8'd2), 2);
        drain();
        check_row("t2", 4, 36);

        // ReLU and saturation corners.
        run_single("t3_sat", 8'd127, 8'd255, 0, 255);
        run_single("t3_relu", 8'hFF, 8'd255, 0, 0);
        run_single("t3_shift", 8'd1, 8'd255, 3, 255);

        // Backpressure: four last-layer beats fill the owed slots.
        load_kernel(0, fill(8'd1));
        do_start(1, 8, 0);
        got_q.delete();
        out_rdy = 1'b0;
        n_dut_acc = 0;
        fork
            begin
                for (int c = 0; c < 8; c++) send(fill(8'(c + 1)), 0);
            end
            begin
                repeat (20) tick();
                check("t4_accepts_stalled", n_dut_acc, 4);
                check("t4_in_rdy_low", in_rdy, 0);
                out_rdy = 1'b1;
            end
        join
        drain();
        check("t4_count", got_q.size(), 8);
        for (int i = 0; i < got_q.size(); i++) begin
            check("t4_pix", got_q[i].pix, 9 * (i + 1));
            check("t4_col", got_q[i].col, i);
        end

        // Config and id errors.
        do_start(1, 3, 0);
        repeat (3) tick();
        check("t5_err_badcfg", cfg_error, 1);
        check("t5_rdy_badcfg", in_rdy, 0);
        load_kernel(0, fill(8'd1));
        do_start(1, 4, 0);
        check("t5_err_cleared", cfg_error, 0);
        got_q.delete();
        send(fill(8'd3), 5);
        check("t5_err_id", cfg_error, 1);
        for (int c = 1; c < 4; c++) send(fill(8'd3), 0);
        drain();
        check_row("t5", 4, 27);
        do_start(1, 4, 0);
        check("t5_err_restart", cfg_error, 0);

        // Reset in the middle of a row.
        got_q.delete();
        send(fill(8'd4), 0);
        send(fill(8'd4), 0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("t6_out_valid", out_valid, 0);
        for (int c = 0; c < 4; c++) send(fill(8'd5), 0);
        drain();
        check_row("t6", 4, 45);

        // Randomized rows with random gaps, random backpressure and occasional bad ids.
        rnd_rdy = 1;
        for (int it = 0; it < 6; it++) begin
            int n, c, sh;
            logic [71:0] px;
            n = int'($urandom_range(1, 4));
            c = int'($urandom_range(4, 10));
            sh = int'($urandom_range(0, 11));
            for (int l = 0; l < n; l++) load_kernel(l, rand72());
            do_start(n, c, sh);
            for (int r = 0; r < 2; r++) begin
                for (int l = 0; l < n; l++) begin
                    for (int k = 0; k < c; k++) begin
                        repeat ($urandom_range(0, 2)) tick();
                        px = rand72();
                        if ($urandom_range(0, 1) == 0) px = px & {9{8'h0F}};
                        send(px, ($urandom_range(0, 19) == 0) ? l + 1 : l);
                    end
                end
            end
            drain();
        end
        rnd_rdy = 0;
        #2;
        out_rdy = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
